// File: rtl/core_pkg.sv
// Shared encodings for the RV32I core front end: pcSrc select codes, fetch FSM states, reset NOP.
// No logic, no latency.
// No flow control; types and constants only.
package core_pkg;

    // pcSrc encodings driven by the control unit
    localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
    localparam logic [1:0] PCSRC_JAL    = 2'b01;
    localparam logic [1:0] PCSRC_BRANCH = 2'b10;
    localparam logic [1:0] PCSRC_JALR   = 2'b11;

    // addi x0, x0, 0 -- harmless word held in instr until the first real fetch lands
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        READY = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selector: PC+4, PC-relative (JAL/branch) or JALR target with bit 0 cleared.
// Purely combinational, zero cycles.
// No flow control; the caller decides when the result is sampled.
module pc_next_calc
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcSrc,
    input  logic [31:0] immPc,
    input  logic [31:0] jalrTarget,
    output logic [31:0] nextPc,
    output logic        misaligned
);

    // Select the successor PC; all adds wrap mod 2^32 by construction
    always_comb begin
        nextPc = pc + 32'd4;
        case (pcSrc)
            PCSRC_PLUS4:  nextPc = pc + 32'd4;
            PCSRC_JAL,
            PCSRC_BRANCH: nextPc = pc + immPc;
            PCSRC_JALR:   nextPc = jalrTarget & ~32'h0000_0001;
            default:      nextPc = pc + 32'd4;
        endcase
    end

    // JALR already has bit 0 cleared, so in practice only bit 1 can flag here
    assign misaligned = (nextPc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: holds PC, fetches over a req/valid imem handshake, hands the word to decode.
// BOOT->FETCH 1 cycle after reset; FETCH lasts until imemValid; READY until advance (2 cycles/instr min).
// imemReq held with a stable address until imemValid; instr held in READY until the core advances.
// Macro FETCH_MISALIGN_TRAP_EN: misaligned next PC redirects to TRAP_VEC with a one-cycle fetchFault
// pulse; without it the next PC is silently word-aligned and fetchFault is tied low.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pcSrc,
    input  logic [31:0] immPc,
    input  logic [31:0] jalrTarget,
    input  logic        advance,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemRdata,
    input  logic        imemValid,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        fetchFault
);

    import core_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;

    logic [31:0]  next_pc;
    logic         misaligned;
    logic [31:0]  pc_target;
    logic         fault_d;

    pc_next_calc u_pc_next_calc (
        .pc         (pc_q),
        .pcSrc      (pcSrc),
        .immPc      (immPc),
        .jalrTarget (jalrTarget),
        .nextPc     (next_pc),
        .misaligned (misaligned)
    );

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    assign pc_target = misaligned ? TRAP_VEC : next_pc;

    // Fault flag is registered so it pulses in the cycle after the redirecting advance
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fetchFault = fault_q;
`else
    logic [34:0] unused_cfg;

    // Low bits are dropped: a misaligned target is quietly rounded down to a word
    assign pc_target  = {next_pc[31:2], 2'b00};
    assign fetchFault = 1'b0;
    assign unused_cfg = {TRAP_VEC, fault_d, next_pc[1:0]};
`endif

    // State, PC and instruction registers; reset abandons any fetch in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state and handshake outputs; imemValid only counts in FETCH, advance only in READY
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        fault_d    = 1'b0;
        imemReq    = 1'b0;
        instrValid = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imemReq = 1'b1;
                if (imemValid) begin
                    instr_d = imemRdata;
                    state_d = READY;
                end
            end
            READY: begin
                instrValid = 1'b1;
                if (advance) begin
                    pc_d    = pc_target;
                    fault_d = misaligned;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imemAddr = pc_q;
    assign pc       = pc_q;
    assign pcPlus4  = pc_q + 32'd4;
    assign instr    = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an imem responder with selectable latency and hand-computed
// expected PCs for sequential, branch, JAL, JALR, wrap, reset-abort and ignored-input cases.
// Expectations for the misaligned-target cases follow FETCH_MISALIGN_TRAP_EN.
module tb_fetch_unit;

    localparam logic [31:0] TRAP = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pcSrc;
    logic [31:0] immPc;
    logic [31:0] jalrTarget;
    logic        advance;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemValid;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        fetchFault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TRAP_VEC (TRAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pcSrc      (pcSrc),
        .immPc      (immPc),
        .jalrTarget (jalrTarget),
        .advance    (advance),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemRdata  (imemRdata),
        .imemValid  (imemValid),
        .instr      (instr),
        .instrValid (instrValid),
        .pc         (pc),
        .pcPlus4    (pcPlus4),
        .fetchFault (fetchFault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a fetch request, sampling on the falling edge
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imemReq === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'(imemReq), 32'd1);
    endtask

    // Answer one fetch: valid is raised in the lat-th cycle the request is seen
    task automatic imem_respond(input int lat, input logic [31:0] word, input logic [31:0] exp_addr);
        bit ok;
        wait_req(ok);
        if (ok) begin
            check("fetch_addr", imemAddr, exp_addr);
            for (int i = 1; i < lat; i++) begin
                @(posedge clk);
                @(negedge clk);
                check("req_held", 32'(imemReq), 32'd1);
                check("addr_stable", imemAddr, exp_addr);
                check("not_ready_in_fetch", 32'(instrValid), 32'd0);
            end
            imemValid = 1'b1;
            imemRdata = word;
            @(posedge clk);
            #1;
            imemValid = 1'b0;
            imemRdata = 32'hBAD0_BAD0;
        end
    endtask

    // Advance from READY, then scramble select/targets so only the advance-cycle values matter
    task automatic advance_with(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] jt,
                                input logic [31:0] exp_pc, input logic exp_fault);
        @(negedge clk);
        check("ready_before_adv", 32'(instrValid), 32'd1);
        pcSrc      = src;
        immPc      = imm;
        jalrTarget = jt;
        advance    = 1'b1;
        @(posedge clk);
        #1;
        advance    = 1'b0;
        pcSrc      = 2'b11;
        immPc      = 32'h0000_4444;
        jalrTarget = 32'h0000_7770;
        @(negedge clk);
        check("pc_after_adv", pc, exp_pc);
        check("req_after_adv", 32'(imemReq), 32'd1);
        check("fault_pulse", 32'(fetchFault), 32'(exp_fault));
        @(negedge clk);
        check("fault_clear", 32'(fetchFault), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        advance    = 1'b0;
        pcSrc      = 2'b00;
        immPc      = 32'h0;
        jalrTarget = 32'h0;
        imemValid  = 1'b0;
        imemRdata  = 32'h0;
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk);
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_valid", 32'(instrValid), 32'd0);
        check("rst_pc", pc, 32'h0000_0000);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_fault", 32'(fetchFault), 32'd0);

        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("boot_no_req", 32'(imemReq), 32'd0);

        // First fetch, 1-cycle latency
        imem_respond(1, 32'h0050_0093, 32'h0000_0000);
        @(negedge clk);
        check("first_valid", 32'(instrValid), 32'd1);
        check("first_instr", instr, 32'h0050_0093);
        check("first_pc", pc, 32'h0000_0000);
        check("first_pc4", pcPlus4, 32'h0000_0004);
        check("ready_no_req", 32'(imemReq), 32'd0);

        // Stale imemValid in READY and pcSrc wiggle without advance: both ignored
        imemValid  = 1'b1;
        imemRdata  = 32'hDEAD_BEEF;
        pcSrc      = 2'b11;
        jalrTarget = 32'h0000_0800;
        @(posedge clk);
        #1;
        imemValid = 1'b0;
        @(negedge clk);
        check("stale_instr_kept", instr, 32'h0050_0093);
        check("no_adv_pc_kept", pc, 32'h0000_0000);
        check("still_ready", 32'(instrValid), 32'd1);

        // Sequential fetches, one with 3-cycle latency
        advance_with(2'b00, 32'h0, 32'h0, 32'h0000_0004, 1'b0);
        imem_respond(3, 32'h0010_0113, 32'h0000_0004);
        @(negedge clk);
        check("seq_instr", instr, 32'h0010_0113);
        check("seq_pc4", pcPlus4, 32'h0000_0008);
        advance_with(2'b00, 32'h0, 32'h0, 32'h0000_0008, 1'b0);
        imem_respond(1, 32'h0000_0013, 32'h0000_0008);
        advance_with(2'b00, 32'h0, 32'h0, 32'h0000_000C, 1'b0);
        imem_respond(1, 32'h0000_0013, 32'h0000_000C);
        advance_with(2'b00, 32'h0, 32'h0, 32'h0000_0010, 1'b0);
        imem_respond(1, 32'hFE00_0CE3, 32'h0000_0010);

        // Taken backward branch: 0x10 + (-8) = 0x08
        advance_with(2'b10, 32'hFFFF_FFF8, 32'h0, 32'h0000_0008, 1'b0);
        imem_respond(1, 32'h0000_0013, 32'h0000_0008);

        // JAL to a misaligned target: 0x08 + 6 = 0x0E
        advance_with(2'b01, 32'h0000_0006, 32'h0, TRAP_ON ? TRAP : 32'h0000_000C, TRAP_ON);
        imem_respond(1, 32'h0000_0013, TRAP_ON ? TRAP : 32'h0000_000C);

        // JALR clears bit 0: 0x201 -> 0x200
        advance_with(2'b11, 32'h0, 32'h0000_0201, 32'h0000_0200, 1'b0);
        imem_respond(1, 32'h0000_0013, 32'h0000_0200);

        // JALR to 0x202: trap with macro, otherwise rounded down to 0x200
        advance_with(2'b11, 32'h0, 32'h0000_0202, TRAP_ON ? TRAP : 32'h0000_0200, TRAP_ON);

        // advance while FETCH has no effect
        @(negedge clk);
        advance = 1'b1;
        pcSrc   = 2'b01;
        immPc   = 32'h0000_0040;
        @(posedge clk);
        #1 advance = 1'b0;
        @(negedge clk);
        check("fetch_adv_pc", pc, TRAP_ON ? TRAP : 32'h0000_0200);
        check("fetch_adv_req", 32'(imemReq), 32'd1);
        check("fetch_adv_valid", 32'(instrValid), 32'd0);

        // Reset mid-FETCH, response arrives the next cycle while in BOOT
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        imemValid = 1'b1;
        imemRdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("abort_pc", pc, 32'h0000_0000);
        check("abort_req", 32'(imemReq), 32'd0);
        check("abort_valid", 32'(instrValid), 32'd0);
        @(posedge clk);
        #1 imemValid = 1'b0;
        @(negedge clk);
        check("abort_stale_valid", 32'(instrValid), 32'd0);
        check("abort_stale_instr", instr, 32'h0000_0013);
        check("abort_refetch_addr", imemAddr, 32'h0000_0000);

        // PC wrap from the top of the address space
        imem_respond(1, 32'h0000_0013, 32'h0000_0000);
        advance_with(2'b11, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
        imem_respond(1, 32'h0000_0013, 32'hFFFF_FFFC);
        @(negedge clk);
        check("top_pc4_wrap", pcPlus4, 32'h0000_0000);
        advance_with(2'b00, 32'h0, 32'h0, 32'h0000_0000, 1'b0);
        imem_respond(1, 32'h0000_0013, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
